// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - Handshaked ALU with an optional iterative shift-add multiplier.
// Define ALU_PIPE_MUL_EN to build the multiplier and its BUSY state; otherwise MUL is illegal.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_illegal, alu_is_mul;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [SHW-1:0]   shamt;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign illegal   = illegal_q;

    assign shamt   = b[SHW-1:0];
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle datapath; MUL is only flagged here and handed to the iterative unit.
    always_comb begin
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        alu_illegal = 1'b0;
        alu_is_mul  = 1'b0;
        case (control)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  alu_is_mul = 1'b1;
`else
            OP_MUL:  alu_illegal = 1'b1;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
        illegal_d = illegal_q;
`ifdef ALU_PIPE_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`endif
        if (state_q == S_DONE && out_ready && !accept)
            state_d = S_IDLE;
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (alu_is_mul) begin
                state_d  = S_BUSY;
                mcand_d  = a;
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
            end else
`endif
            begin
                state_d   = S_DONE;
                result_d  = alu_res;
                z_d       = !alu_illegal && (alu_res == '0);
                n_d       = alu_res[WIDTH-1];
                c_d       = alu_c;
                v_d       = alu_v;
                illegal_d = alu_illegal;
            end
        end
        if (state_q == S_BUSY) begin
`ifdef ALU_PIPE_MUL_EN
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // The last step writes the sum straight to the output so DONE lands WIDTH cycles after BUSY.
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d   = S_DONE;
                result_d  = acc_step;
                z_d       = (acc_step == '0);
                n_d       = acc_step[WIDTH-1];
                c_d       = 1'b0;
                v_d       = 1'b0;
                illegal_d = 1'b0;
            end
`else
            state_d = S_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
            v_q       <= v_d;
            illegal_q <= illegal_d;
`ifdef ALU_PIPE_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - Directed self-checking bench for alu_pipe (WIDTH=32).
module tb_alu_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   control = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, illegal;
    logic [W-1:0] result;
    logic [W+4:0] obs;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .flag_v(flag_v), .illegal(illegal)
    );

    // {result, z, n, c, v, illegal}
    assign obs = {result, flag_z, flag_n, flag_c, flag_v, illegal};

    task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          output int lat, output int rdy_hits);
        control  = ctl;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        rdy_hits = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_hits++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        int lat, rh;
        run_op(4'h0, 32'h7FFFFFFF, 32'h00000001, lat, rh);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (obs !== {32'h80000000, 5'b01010}) begin errors++; $display("FAIL add_ovf got=%h exp=%h", obs, {32'h80000000, 5'b01010}); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_to_idle got=%b exp=0", out_valid); end
        run_op(4'h1, 32'd5, 32'd5, lat, rh);
        checks++; if (obs !== {32'h0, 5'b10100}) begin errors++; $display("FAIL sub_equal got=%h exp=%h", obs, {32'h0, 5'b10100}); end
        consume();
        run_op(4'h1, 32'd0, 32'd1, lat, rh);
        checks++; if (obs !== {32'hFFFFFFFF, 5'b01000}) begin errors++; $display("FAIL sub_borrow got=%h exp=%h", obs, {32'hFFFFFFFF, 5'b01000}); end
        consume();
    endtask

    task automatic test_logic_shift();
        int lat, rh;
        run_op(4'h5, 32'hFFFFFFFF, 32'h1, lat, rh);
        checks++; if (obs !== {32'h1, 5'b00000}) begin errors++; $display("FAIL slt got=%h exp=%h", obs, {32'h1, 5'b00000}); end
        consume();
        run_op(4'h6, 32'hFFFFFFFF, 32'h1, lat, rh);
        checks++; if (obs !== {32'h0, 5'b10000}) begin errors++; $display("FAIL sltu got=%h exp=%h", obs, {32'h0, 5'b10000}); end
        consume();
        run_op(4'h9, 32'h80000000, 32'd33, lat, rh);
        checks++; if (obs !== {32'hC0000000, 5'b01000}) begin errors++; $display("FAIL sra got=%h exp=%h", obs, {32'hC0000000, 5'b01000}); end
        consume();
        run_op(4'h8, 32'h80000000, 32'd31, lat, rh);
        checks++; if (obs !== {32'h1, 5'b00000}) begin errors++; $display("FAIL srl got=%h exp=%h", obs, {32'h1, 5'b00000}); end
        consume();
        run_op(4'h7, 32'h1, 32'h21, lat, rh);
        checks++; if (obs !== {32'h2, 5'b00000}) begin errors++; $display("FAIL sll got=%h exp=%h", obs, {32'h2, 5'b00000}); end
        consume();
        run_op(4'h2, 32'h0000F0F0, 32'h00000FF0, lat, rh);
        checks++; if (obs !== {32'h000000F0, 5'b00000}) begin errors++; $display("FAIL and got=%h exp=%h", obs, {32'h000000F0, 5'b00000}); end
        consume();
        run_op(4'h3, 32'h80000000, 32'h00000001, lat, rh);
        checks++; if (obs !== {32'h80000001, 5'b01000}) begin errors++; $display("FAIL or got=%h exp=%h", obs, {32'h80000001, 5'b01000}); end
        consume();
        run_op(4'h4, 32'h12345678, 32'h12345678, lat, rh);
        checks++; if (obs !== {32'h0, 5'b10000}) begin errors++; $display("FAIL xor got=%h exp=%h", obs, {32'h0, 5'b10000}); end
        consume();
    endtask

    task automatic test_mul();
        int lat, rh;
        logic [W+4:0] exp_v;
        int exp_lat;
`ifdef ALU_PIPE_MUL_EN
        exp_v   = {32'h00020001, 5'b00000};
        exp_lat = 33;
`else
        exp_v   = {32'h0, 5'b00001};
        exp_lat = 1;
`endif
        run_op(4'hA, 32'h00010001, 32'h00010001, lat, rh);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", lat, exp_lat); end
        checks++; if (rh !== 0) begin errors++; $display("FAIL mul_busy_ready got=%0d exp=0", rh); end
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL mul_result got=%h exp=%h", obs, exp_v); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== exp_v) begin
                errors++;
                $display("FAIL mul_hold cycle=%0d valid=%b ready=%b got=%h exp=%h", i, out_valid, in_ready, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        control   = 4'h0;
        a         = 32'd3;
        b         = 32'd4;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || obs !== {32'd7, 5'b00000}) begin errors++; $display("FAIL b2b_add valid=%b got=%h exp=%h", out_valid, obs, {32'd7, 5'b00000}); end
        control = 4'hF;
        a       = 32'd5;
        b       = 32'd6;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || obs !== {32'h0, 5'b00001}) begin errors++; $display("FAIL b2b_illegal valid=%b got=%h exp=%h", out_valid, obs, {32'h0, 5'b00001}); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int hits;
        control  = 4'hA;
        a        = 32'h0000FFFF;
        b        = 32'h00000003;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midmul_reset valid=%b ready=%b exp 0/1", out_valid, in_ready); end
        checks++; if (obs !== '0) begin errors++; $display("FAIL midmul_reset_outputs got=%h exp=0", obs); end
        @(negedge clk); rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL midmul_stale got=%0d exp=0", hits); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 control  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL; all others illegal.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  WIDTH  registered result.
REQ-012 flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative (result MSB), carry, signed overflow.
REQ-013 illegal  output  1  registered; high with out_valid when the accepted opcode was illegal.

Function
REQ-014 Accept SHALL occur when in_valid and in_ready are both high; a, b, control are sampled at accept.
REQ-015 State machine SHALL have states IDLE, BUSY, DONE; in_ready high in IDLE, and in DONE when out_ready is high; low in BUSY.
REQ-016 Single-cycle ops and illegal opcodes SHALL go accept -> DONE, out_valid high the cycle after accept (latency 1).
REQ-017 MUL SHALL go accept -> BUSY, iterate one shift-add step per cycle for WIDTH cycles, then DONE; out_valid high WIDTH+1 cycles after accept; result is low WIDTH bits of a*b.
REQ-018 DONE SHALL hold result, flags, illegal stable while out_valid high and out_ready low.
REQ-019 In DONE with out_ready high: with a new accept in the same cycle, go to DONE or BUSY per the new opcode; otherwise go to IDLE and drop out_valid.
REQ-020 SUB SHALL compute a + ~b + 1; flag_c is carry-out of bit WIDTH-1 (1 = no borrow); ADD flag_c is carry-out.
REQ-021 flag_v SHALL be signed overflow for ADD/SUB, 0 for all other ops; flag_c 0 for non-ADD/SUB ops.
REQ-022 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH, signed/unsigned compare respectively.
REQ-023 Shifts SHALL use only the low clog2(WIDTH) bits of b as shift amount; SRA replicates a's MSB.
REQ-024 flag_z and flag_n SHALL reflect result for every legal op.
REQ-025 Illegal opcode SHALL yield result 0, all flags 0, illegal 1.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, all flags 0, illegal 0, multiplier state cleared; in_ready 1 while in reset.
REQ-027 Reset asserted during BUSY SHALL abort the multiply with no result delivered.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN defined SHALL compile in the iterative multiplier and BUSY state as in REQ-017.
REQ-029 Without ALU_PIPE_MUL_EN, opcode 1010 SHALL be treated as illegal per REQ-025 with latency 1, and BUSY is unreachable.

Verification (WIDTH=32, MUL enabled unless stated)
REQ-030 ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, n=1 v=1 c=0 z=0, out_valid one cycle after accept.
REQ-031 SUB a=5 b=5 -> result 0, z=1 c=1 v=0; SUB a=0 b=1 -> 0xFFFFFFFF, c=0 n=1.
REQ-032 SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0; SRA a=0x80000000 b=33 -> 0xC0000000.
REQ-033 MUL a=0x00010001 b=0x00010001 -> 0x00020001 exactly 33 cycles after accept, in_ready low throughout BUSY; out_ready low 5 cycles -> outputs held stable.
REQ-034 Back-to-back: DONE with out_ready=1 and new ADD accepted same cycle -> next cycle new result, out_valid stays high; control=1111 -> illegal=1, result 0.
REQ-035 rst_n pulsed low mid-MUL -> out_valid 0 immediately, in_ready 1, no stale result after release; without ALU_PIPE_MUL_EN, MUL -> illegal=1 after 1 cycle.
